muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A (dividend / multiplicand), driven from register-file read port 1.
REQ-007 rs2_data  input  32  operand B (divisor / multiplier), driven from register-file read port 2.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-010 result  output  32  op result; held stable from done until the next accepted start.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE; DONE -> IDLE unconditionally after one cycle.
REQ-012 start SHALL be accepted only in IDLE; start while busy=1 (CALC or DONE) SHALL be ignored with no side effects.
REQ-013 On acceptance, funct3, rs1_data and rs2_data SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-014 Timing reference: the cycle in which start is sampled is cycle 0.
REQ-015 Normal ops: IDLE -> CALC; 32 iterations, one bit per cycle, in cycles 1..32; DONE in cycle 33 (done=1, busy=1).
REQ-016 The iteration counter SHALL be 5 bits, cleared on entry to CALC, and SHALL exit to DONE when it reaches 31.
REQ-017 Multiply SHALL use shift-add on operand magnitudes with a 64-bit accumulator.
REQ-018 Sign fix-up SHALL be applied on entry to DONE.
REQ-019 MUL SHALL return product[31:0].
REQ-020 MULH (signed x signed), MULHSU (rs1 signed x rs2 unsigned) and MULHU (unsigned x unsigned) SHALL return product[63:32].
REQ-021 Divide SHALL use restoring division on magnitudes.
REQ-022 Signed quotient SHALL be negative iff operand signs differ; signed remainder SHALL take the sign of the dividend.
REQ-023 Divide by zero SHALL skip CALC (IDLE -> DONE, done in cycle 1): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1_data.
REQ-024 Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF) SHALL skip CALC (done in cycle 1): DIV -> 0x80000000; REM -> 0.
REQ-025 Zero multiplier or zero dividend SHALL NOT be special-cased (full 33-cycle latency).
REQ-026 Back-to-back: a start in the cycle after done SHALL be accepted.
REQ-027 done SHALL be high for exactly one cycle per accepted start and never otherwise.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, counter 0, busy=0, done=0, result=0x00000000, all internal registers 0.
REQ-029 Reset mid-operation SHALL abort the op; no done SHALL follow reset release.
REQ-030 start SHALL be ignored while rst=1; the first start after release SHALL be accepted.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD -> busy=1 cycles 1..33; done=1 only in cycle 33; result 0xFFFFFFEB.
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2; done in cycle 33.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; each with done in cycle 1.
REQ-035 Start MUL; pulse start with new operands in cycle 5 -> ignored, original result produced in cycle 33; next start in cycle 34 -> accepted.
REQ-036 Start MUL; assert rst in cycle 10, asynchronously -> busy, done, result 0 before the next edge; after release, no done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per
// clock, always on operand magnitudes. The sign is restored as the result
// is registered. Divide-by-zero and signed overflow bypass the iteration
// and complete in one cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [31:0] opnd;    // multiplicand for MUL*, divisor for DIV*/REM*
  logic [63:0] acc;     // {hi, lo}: product, or {remainder, quotient}
  logic        neg_q;   // negate product / quotient at the end
  logic        neg_r;   // negate remainder at the end

  logic        is_div, rs1_sgn, rs2_sgn, s1, s2;
  logic [31:0] m1, m2;
  logic        div_zero, div_ovf;
  logic [31:0] spec_res;

  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] quot_f, rem_f;
  logic [31:0] fix_res;

  // Decode the incoming request: operand signedness, magnitudes, special cases.
  always_comb begin
    is_div   = funct3[2];
    rs1_sgn  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    rs2_sgn  = is_div ? ~funct3[0] : ~funct3[1];
    s1       = rs1_sgn & rs1_data[31];
    s2       = rs2_sgn & rs2_data[31];
    m1       = s1 ? (~rs1_data + 32'd1) : rs1_data;
    m2       = s2 ? (~rs2_data + 32'd1) : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = is_div && !funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == '1);
    if (div_zero)
      spec_res = funct3[1] ? rs1_data : '1;
    else
      spec_res = funct3[1] ? '0 : 32'h8000_0000;
  end

  // One iteration of shift-add or restoring division, plus the sign fix-up
  // applied to the value the final iteration produces.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_top = acc[63:31];
    div_ge  = (div_top >= {1'b0, opnd});
    div_rem = div_top[31:0] - opnd;
    if (op[2]) begin
      if (div_ge)
        acc_step = {div_rem, acc[30:0], 1'b1};
      else
        acc_step = {acc[62:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[31:1]};
    end
    prod   = neg_q ? (~acc_step + 64'd1) : acc_step;
    quot_f = neg_q ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem_f  = neg_r ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
    if (op[2])
      fix_res = op[1] ? rem_f : quot_f;
    else
      fix_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      opnd   <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op    <= funct3;
            opnd  <= is_div ? m2 : m1;
            acc   <= {32'd0, (is_div ? m1 : m2)};
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            busy  <= 1'b1;
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= spec_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= fix_res;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit against a scoreboard of
// expected result and latency per accepted start.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent RV32M reference built on wide signed/unsigned arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    up  = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_op = '0;
    case (f)
      3'd0: begin p = sa * sb; ref_op = p[31:0];  end
      3'd1: begin p = sa * sb; ref_op = p[63:32]; end
      3'd2: begin p = sa * ub; ref_op = p[63:32]; end
      3'd3: ref_op = up[63:32];
      3'd4: ref_op = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_op = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: ref_op = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Drive a start for one cycle (sampled at the next rising edge) and record the expectation.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    e.res = exp;
    e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Follow the accepted op to done, optionally pulsing a second start in cycle pulse_cycle.
  task automatic wait_done(input string tag, input int pulse_cycle);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    start    = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      if (n == pulse_cycle) begin
        start    = 1'b1;
        funct3   = 3'b101;
        rs1_data = 32'd100;
        rs2_data = 32'd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    e = sb_q.pop_front();
    check({tag, " done"},    32'(done), 32'd1);
    check({tag, " latency"}, 32'(n),    32'(e.lat));
    check({tag, " busy@done"}, 32'(busy), 32'd1);
    check({tag, " result"},  result,    e.res);
    @(posedge clk); #1;
    check({tag, " done-after"}, 32'(done), 32'd0);
    check({tag, " busy-after"}, 32'(busy), 32'd0);
    check({tag, " result-held"}, result, e.res);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(f, a, b, exp, lat);
    wait_done(tag, 0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic        saw;

    rst      = 1'b1;
    start    = 1'b1;
    funct3   = 3'b000;
    rs1_data = 32'd7;
    rs2_data = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   32'(busy), 32'd0);
    check("reset done",   32'(done), 32'd0);
    check("reset result", result,    32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    run("mul 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulh min*min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    run("mulhu max*max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mulhsu -1*max",   3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run("div -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run("rem -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run("divu 100/7",      3'b101, 32'd100,        32'd7,         32'd14,        33);
    run("remu 100/7",      3'b111, 32'd100,        32'd7,         32'd2,         33);
    run("mul zero",        3'b000, 32'd0,          32'd12345,     32'd0,         33);
    run("divu zero num",   3'b101, 32'd0,          32'd3,         32'd0,         33);
    run("divu 5/0",        3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run("remu 5/0",        3'b111, 32'd5,          32'd0,         32'd5,         1);
    run("div ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    run("div -7/0",        3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1);
    run("rem -7/0",        3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);
    run("rem 7/-2",        3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33);

    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, ref_op(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    // A start during CALC must be ignored; the next op follows immediately after done.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    wait_done("mul ignore-start", 5);
    run("back-to-back divu", 3'b101, 32'd1000, 32'd9, 32'd111, 33);

    // Asynchronous reset in the middle of an op.
    @(negedge clk);
    start    = 1'b1;
    funct3   = 3'b000;
    rs1_data = 32'd7;
    rs2_data = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst   = 1'b1;
    start = 1'b1;
    #1;
    check("async rst busy",   32'(busy), 32'd0);
    check("async rst done",   32'(done), 32'd0);
    check("async rst result", result,    32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("in-reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    check("no done after reset", 32'(saw), 32'd0);
    run("first after reset", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
